// File: rtl/cacheline_adaptor_if.sv
// Cache-side (pmem_*) and memory-side (burst_*) signals of the cacheline adaptor.
// The adaptor uses the slave modport; the environment driving it uses master.
interface cacheline_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [31:0]        pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [s_line-1:0]  pmem_wdata;
  logic [s_line-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic [31:0]        burst_address;
  logic               burst_read;
  logic               burst_write;
  logic [s_burst-1:0] burst_wdata;
  logic [s_burst-1:0] burst_rdata;
  logic               burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits a cache line into s_line/s_burst memory beats and reassembles read beats.
// Optional stall watchdog: define ADAPTOR_TIMEOUT_EN.

// One read-data lane: captures its beat of the line and holds it until the next read.
module cacheline_adaptor_beat #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  cacheline_adaptor_if.slave     bus,
  output logic                   err_o
);
  localparam int BEATS = s_line / s_burst;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [31:0]                    addr_q;
  logic [s_line-1:0]              wdata_q;
  logic                           rd_q, wr_q, resp_q;
  logic [BEATS-1:0]               beat_we;
  logic [BEATS-1:0][s_burst-1:0]  rdata;
`ifdef ADAPTOR_TIMEOUT_EN
  logic [7:0]                     to_q;
  logic                           err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
`ifdef ADAPTOR_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.pmem_write) begin
            addr_q  <= bus.pmem_address;
            wdata_q <= bus.pmem_wdata;
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end else if (bus.pmem_read) begin
            addr_q  <= bus.pmem_address;
            rd_q    <= 1'b1;
            state_q <= READ;
          end
        end
        READ, WRITE: begin
          if (bus.burst_resp) begin
            cnt_q <= cnt_q + CW'(1);
            // Write line is shifted so the current beat always sits in the low slice.
            if (state_q == WRITE) wdata_q <= wdata_q >> s_burst;
            if (cnt_q == LAST) begin
              state_q <= DONE;
              rd_q    <= 1'b0;
              wr_q    <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
`ifdef ADAPTOR_TIMEOUT_EN
          // 255th consecutive stalled cycle gives up and returns whatever arrived.
          if (bus.burst_resp) begin
            to_q <= '0;
          end else if (to_q == 8'd254) begin
            to_q    <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
          end else begin
            to_q <= to_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_lane
    assign beat_we[k] = (state_q == READ) && bus.burst_resp && (cnt_q == CW'(k));
    cacheline_adaptor_beat #(.W(s_burst)) u_beat (
      .clk   (clk),
      .rst_n (rst),
      .we_i  (beat_we[k]),
      .d_i   (bus.burst_rdata),
      .q_o   (rdata[k])
    );
  end

  assign bus.pmem_rdata    = rdata;
  assign bus.pmem_resp     = resp_q;
  assign bus.burst_address = addr_q;
  assign bus.burst_read    = rd_q;
  assign bus.burst_write   = wr_q;
  assign bus.burst_wdata   = wdata_q[s_burst-1:0];

`ifdef ADAPTOR_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor against a transaction-level line/latency model.
module tb_cacheline_adaptor;
  localparam int SL = 256;
  localparam int SB = 64;
  localparam int NB = SL / SB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_o;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [SL-1:0] last_rd = '0;

  cacheline_adaptor_if #(.s_line(SL), .s_burst(SB)) bus();

  cacheline_adaptor #(.s_line(SL), .s_burst(SB)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [SB-1:0] rword();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [SL-1:0] rline();
    logic [SL-1:0] l;
    l = '0;
    for (int i = 0; i < NB; i++) l = (l << SB) | SL'(rword());
    return l;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp"},  SL'(bus.pmem_resp), '0);
    chk({tag, "_brd"},   SL'(bus.burst_read), '0);
    chk({tag, "_bwr"},   SL'(bus.burst_write), '0);
    chk({tag, "_baddr"}, SL'(bus.burst_address), '0);
    chk({tag, "_bwdat"}, SL'(bus.burst_wdata), '0);
    chk({tag, "_rdata"}, bus.pmem_rdata, '0);
    chk({tag, "_err"},   SL'(err_o), '0);
  endtask

  // Idle cycles with noise on burst_resp/rdata, which the adaptor must ignore.
  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_brd",   SL'(bus.burst_read), '0);
      chk("idle_bwr",   SL'(bus.burst_write), '0);
      chk("idle_resp",  SL'(bus.pmem_resp), '0);
      chk("idle_rdata", bus.pmem_rdata, last_rd);
      bus.pmem_read   = 1'b0;
      bus.pmem_write  = 1'b0;
      bus.burst_resp  = 1'($urandom_range(1));
      bus.burst_rdata = rword();
    end
    @(negedge clk);
    bus.burst_resp = 1'b0;
  endtask

  // One cache transaction. gaps[j] = idle memory cycles before beat j.
  task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                     input logic [SL-1:0] wline, input logic [SB-1:0] beats [NB],
                     input int gaps [NB]);
    logic [SL-1:0] exp_line;
    logic [SB-1:0] slice;
    int exp_resp, j, waited;
    bit got;
    exp_line = '0;
    exp_resp = NB + 1;
    for (int k = 0; k < NB; k++) begin
      exp_line = exp_line | (SL'(beats[k]) << (k * SB));
      exp_resp = exp_resp + gaps[k];
    end
    bus.pmem_address = addr;
    bus.pmem_write   = wr;
    bus.pmem_read    = !wr || both;
    bus.pmem_wdata   = wline;
    bus.burst_resp   = 1'b0;
    j = 0; waited = 0; got = 0;
    for (int cyc = 1; cyc <= exp_resp + 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        got = 1;
        if (!wr) last_rd = exp_line;
        chk("resp_cycle", SL'(cyc), SL'(exp_resp));
        chk("beats_used", SL'(j), SL'(NB));
        chk("done_brd",   SL'(bus.burst_read), '0);
        chk("done_bwr",   SL'(bus.burst_write), '0);
        chk("done_rdata", bus.pmem_rdata, last_rd);
        chk("done_err",   SL'(err_o), '0);
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.burst_resp  = 1'($urandom_range(1));
        bus.burst_rdata = rword();
      end else begin
        chk("req_brd",   SL'(bus.burst_read), SL'(!wr));
        chk("req_bwr",   SL'(bus.burst_write), SL'(wr));
        chk("req_baddr", SL'(bus.burst_address), SL'(addr));
        if (wr) begin
          slice = SB'(wline >> (j * SB));
          chk("req_bwdata", SL'(bus.burst_wdata), SL'(slice));
        end
        bus.pmem_address = $urandom & ~32'h1f;
        bus.pmem_wdata   = rline();
        if (j < NB && waited >= gaps[j]) begin
          bus.burst_resp  = 1'b1;
          bus.burst_rdata = beats[j];
          j++;
          waited = 0;
        end else begin
          bus.burst_resp  = 1'b0;
          bus.burst_rdata = rword();
          if (j < NB) waited++;
        end
      end
    end
    if (!got) chk("resp_timeout", '0, SL'(1));
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    @(negedge clk);
    chk("resp_pulse", SL'(bus.pmem_resp), '0);
    chk("post_rdata", bus.pmem_rdata, last_rd);
    bus.burst_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    last_rd = '0;
    chk_all_zero("rst");
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.burst_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_resp", SL'(bus.pmem_resp), '0);
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [SB-1:0] b [NB];
    int g [NB];
    bit wr;

    bus.pmem_address = '0; bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
    bus.pmem_wdata = '0; bus.burst_rdata = '0; bus.burst_resp = 1'b0;
    #12;
    chk_all_zero("por");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Directed back-to-back read
    b = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
    g = '{0, 0, 0, 0};
    txn(0, 0, 32'h0000_1240, '0, b, g);
    idle(3);

    // Directed write, beats leave LSB first
    txn(1, 0, 32'h0000_2000,
        {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA},
        b, g);
    idle(2);

    // Read with 3-cycle gaps between beats
    b = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
    g = '{0, 3, 3, 3};
    txn(0, 0, 32'h0000_3460, '0, b, g);
    idle(2);

    // Read and write together: the write wins
    g = '{1, 0, 2, 0};
    txn(1, 1, 32'h0000_4000, rline(), b, g);
    idle(2);

    // Reset after three beats of a read aborts it
    bus.pmem_address = 32'h0000_5000;
    bus.pmem_read    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = rword();
    end
    do_reset();
    idle(2);
    for (int k = 0; k < NB; k++) begin b[k] = rword(); g[k] = 0; end
    txn(0, 0, 32'h0000_5000, '0, b, g);
    idle(1);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(1));
      for (int k = 0; k < NB; k++) begin
        b[k] = rword();
        g[k] = $urandom_range(3);
      end
      txn(wr, wr && 1'($urandom_range(1)), $urandom & ~32'h1f, rline(), b, g);
      idle($urandom_range(3));
    end

    // Memory never answers
    bus.pmem_address = 32'h0000_6000;
    bus.pmem_read    = 1'b1;
    bus.burst_resp   = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
`ifdef ADAPTOR_TIMEOUT_EN
      if (cyc == 256) begin
        chk("to_resp", SL'(bus.pmem_resp), SL'(1));
        chk("to_err",  SL'(err_o), SL'(1));
        break;
      end
`endif
      chk("stall_brd",  SL'(bus.burst_read), SL'(1));
      chk("stall_resp", SL'(bus.pmem_resp), '0);
      chk("stall_err",  SL'(err_o), '0);
    end
    bus.pmem_read = 1'b0;
    do_reset();
    idle(1);
    for (int k = 0; k < NB; k++) begin b[k] = rword(); g[k] = 1; end
    txn(0, 0, 32'h0000_7000, '0, b, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL provide parameter s_line, default 256, cache line width in bits.
REQ-002 SHALL provide parameter s_burst, default 64, memory beat width; beats per line = s_line/s_burst (4 at defaults).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-005 SHALL provide port pmem_address  input  32  line address from cache, line-aligned (low 5 bits zero).
REQ-006 SHALL provide port pmem_read  input  1  cache line read request, held until pmem_resp.
REQ-007 SHALL provide port pmem_write  input  1  cache line write request, held until pmem_resp.
REQ-008 SHALL provide port pmem_wdata  input  s_line  line to write back.
REQ-009 SHALL provide port pmem_rdata  output  s_line  assembled line for a read.
REQ-010 SHALL provide port pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL provide port burst_address  output  32  registered copy of pmem_address.
REQ-012 SHALL provide port burst_read / burst_write  output  1 each  memory-side requests.
REQ-013 SHALL provide port burst_wdata  output  s_burst  current write beat.
REQ-014 SHALL provide port burst_rdata  input  s_burst  returned read beat.
REQ-015 SHALL provide port burst_resp  input  1  memory accepts/returns exactly one beat per asserted cycle.
REQ-016 SHALL provide port err_o  output  1  sticky timeout flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-018 IDLE: pmem_write=1 -> latch pmem_wdata and pmem_address, go WRITE; else pmem_read=1 -> latch address, go READ; both high -> write wins.
REQ-019 burst_read high exactly while in READ; burst_write high exactly while in WRITE; first request cycle is the cycle after the request is sampled.
REQ-020 Beat counter (2 bits at defaults) SHALL start at 0 and increment only on burst_resp=1 in READ/WRITE; burst_resp gaps hold the counter.
REQ-021 READ: beat k of burst_rdata SHALL be written into pmem_rdata[k*s_burst +: s_burst]; beat 0 is least significant.
REQ-022 WRITE: burst_wdata SHALL equal latched line slice k for current count k.
REQ-023 On burst_resp with count = last beat, SHALL go DONE; burst_read/burst_write low in DONE.
REQ-024 DONE: pmem_resp=1 for exactly one cycle, pmem_rdata stable, then IDLE unconditionally.
REQ-025 pmem_rdata SHALL hold its value in IDLE until the next read's first beat.
REQ-026 Minimum read/write latency: request sampled cycle 0, burst_* cycle 1, pmem_resp cycle 5 with 4 back-to-back beats.
REQ-027 burst_resp in IDLE or DONE SHALL be ignored.
REQ-028 Request changes on pmem_* outside IDLE SHALL be ignored (address/data latched).

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, beat count 0, pmem_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, pmem_rdata=0, err_o=0.
REQ-030 Reset mid-burst SHALL abort the transfer with no pmem_resp; operation restarts from IDLE after rst=1.

Configuration
REQ-031 Macro ADAPTOR_TIMEOUT_EN: when defined, 8-bit counter SHALL count consecutive READ/WRITE cycles without burst_resp, clearing on each burst_resp.
REQ-032 With ADAPTOR_TIMEOUT_EN, reaching 255 SHALL set err_o (sticky until reset) and force DONE, pulsing pmem_resp with partial data.
REQ-033 Without ADAPTOR_TIMEOUT_EN, err_o SHALL be tied 0, no counter SHALL exist, and the adaptor waits indefinitely.

Verification
REQ-034 Read 0x0000_1240, beats 0x11..11,0x22..22,0x33..33,0x44..44 back-to-back -> burst_address=0x0000_1240, pmem_resp cycle 5, pmem_rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-035 Write line 0xDDDD..CCCC..BBBB..AAAA (64-bit slices) -> burst_wdata 0xAAAA..,0xBBBB..,0xCCCC..,0xDDDD.. in order, one pmem_resp pulse.
REQ-036 Read with burst_resp gaps of 3 idle cycles between beats -> same assembled line, pmem_resp cycle 14, counter holds during gaps.
REQ-037 pmem_read and pmem_write both high in IDLE -> WRITE entered, burst_read never asserted.
REQ-038 rst pulsed low after beat 2 of a read -> all outputs 0 immediately, no pmem_resp; subsequent read completes correctly.
REQ-039 With ADAPTOR_TIMEOUT_EN, read with no burst_resp -> err_o=1 and pmem_resp after 255 stalled cycles; without macro, err_o stays 0 and burst_read stays high.
